// File: rtl/ddr3_command_responder.sv
// ddr3_command_responder
// Device-side stand-in for a DDR3 chip, clocked at single data rate.
// It decodes the command pins and keeps an open/closed flag and open row per bank.
// Write bursts go into a small on-chip array, and read bursts come back after CAS latency.
// Scheduled data windows never overlap. One burst engine therefore serves both
// directions, fed by a read and a write latency pipe.

module ddr3_command_responder #(
    parameter int ADDRESS_BITWIDTH      = 15,
    parameter int BANK_ADDRESS_BITWIDTH = 3,
    parameter int DQ_BITWIDTH           = 16,
    parameter int CAS_LATENCY           = 5,
    parameter int CAS_WRITE_LATENCY     = 5,
    parameter int BURST_LENGTH          = 8,
    parameter int STORAGE_DEPTH_BITS    = 6
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             ck_en,
    input  logic                             cs_n,
    input  logic                             ras_n,
    input  logic                             cas_n,
    input  logic                             we_n,
    input  logic [ADDRESS_BITWIDTH-1:0]      address,
    input  logic [BANK_ADDRESS_BITWIDTH-1:0] bank_address,
    input  logic [DQ_BITWIDTH-1:0]           dq_in,
    output logic [DQ_BITWIDTH-1:0]           dq_out,
    output logic                             dq_oe,
    output logic                             dqs_out,
    output logic                             dqs_oe,
    output logic                             protocol_error,
    output logic [7:0]                       error_count,
    output logic [15:0]                      refresh_count
);

    localparam int NUM_BANKS     = 1 << BANK_ADDRESS_BITWIDTH;
    localparam int STORAGE_DEPTH = 1 << STORAGE_DEPTH_BITS;
    localparam int MAX_LATENCY   = (CAS_LATENCY > CAS_WRITE_LATENCY) ? CAS_LATENCY : CAS_WRITE_LATENCY;
    localparam int REM_W         = $clog2(MAX_LATENCY + BURST_LENGTH) + 1;
    localparam int SDB           = STORAGE_DEPTH_BITS;

    typedef enum logic [2:0] {
        CMD_MRS = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_ZQ  = 3'b110,
        CMD_NOP = 3'b111
    } cmd_e;

    // Even parity over a vector; folds diagnostic-only state into one bit
    function automatic logic parity_f(input logic [ADDRESS_BITWIDTH*2-1:0] vec);
        parity_f = ^vec;
    endfunction

    cmd_e                        cmd_s;
    logic [NUM_BANKS-1:0]        bank_open_r;
    logic [NUM_BANKS-1:0]        bank_open_nxt_s;
    logic [ADDRESS_BITWIDTH-1:0] bank_row_r [NUM_BANKS];
    logic [ADDRESS_BITWIDTH-1:0] row_fold_s;
    logic                        row_load_s;
    logic                        sel_open_s;
    logic                        cmd_err_s;
    logic                        ref_ok_s;
    logic                        rd_acc_s;
    logic                        wr_acc_s;
    logic [REM_W-1:0]            sched_rem_r;

    logic [CAS_LATENCY-1:0]       rd_vld_r;
    logic [SDB-1:0]               rd_col_r [CAS_LATENCY];
    logic [CAS_WRITE_LATENCY-1:0] wr_vld_r;
    logic [SDB-1:0]               wr_col_r [CAS_WRITE_LATENCY];

    logic           beat_go_s;
    logic           beat_wr_s;
    logic [2:0]     beat_idx_s;
    logic [SDB-1:0] beat_col_s;
    logic [2:0]     beat_wrap_s;
    logic [SDB-1:0] beat_addr_s;
    logic           rd_beat_s;

    logic           burst_active_r;
    logic [2:0]     burst_beat_r;
    logic           burst_wr_r;
    logic [SDB-1:0] burst_col_r;

    logic [DQ_BITWIDTH-1:0] mem_r [STORAGE_DEPTH];

    logic [DQ_BITWIDTH-1:0] dq_out_r;
    logic                   dq_oe_r;
    logic                   dqs_out_r;
    logic                   protocol_error_r;
    logic [7:0]             error_count_r;
    logic [15:0]            refresh_count_r;

    logic unused_s;

    assign sel_open_s = bank_open_r[bank_address];

    // Command pins to command; CKE low or chip deselected reads as NOP
    always_comb begin
        cmd_s = CMD_NOP;
        if (ck_en && !cs_n) begin
            cmd_s = cmd_e'({ras_n, cas_n, we_n});
        end else begin
            cmd_s = CMD_NOP;
        end
    end

    // Legality check and next bank state for the command on this edge
    always_comb begin
        bank_open_nxt_s = bank_open_r;
        row_load_s      = 1'b0;
        cmd_err_s       = 1'b0;
        ref_ok_s        = 1'b0;
        rd_acc_s        = 1'b0;
        wr_acc_s        = 1'b0;
        case (cmd_s)
            CMD_REF: begin
                if (|bank_open_r) begin
                    cmd_err_s = 1'b1;
                end else begin
                    ref_ok_s = 1'b1;
                end
            end
            CMD_PRE: begin
                if (address[10]) begin
                    bank_open_nxt_s = '0;
                end else begin
                    bank_open_nxt_s[bank_address] = 1'b0;
                end
            end
            CMD_ACT: begin
                if (sel_open_s) begin
                    cmd_err_s = 1'b1;
                end else begin
                    bank_open_nxt_s[bank_address] = 1'b1;
                    row_load_s                    = 1'b1;
                end
            end
            CMD_WR: begin
                // The new window must start strictly after the last scheduled beat
                if (!sel_open_s || (REM_W'(CAS_WRITE_LATENCY) <= sched_rem_r)) begin
                    cmd_err_s = 1'b1;
                end else begin
                    wr_acc_s = 1'b1;
                end
            end
            CMD_RD: begin
                if (!sel_open_s || (REM_W'(CAS_LATENCY) <= sched_rem_r)) begin
                    cmd_err_s = 1'b1;
                end else begin
                    rd_acc_s = 1'b1;
                end
            end
            CMD_MRS, CMD_ZQ, CMD_NOP: begin
                cmd_err_s = 1'b0;
            end
            default: begin
                cmd_err_s = 1'b0;
            end
        endcase
    end

    // Bank open flags; closed on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_open_r <= '0;
        end else begin
            bank_open_r <= bank_open_nxt_s;
        end
    end

    // Open row recorded per bank on an accepted ACT
    always_ff @(posedge clk) begin
        if (!reset && row_load_s) begin
            bank_row_r[bank_address] <= address;
        end
    end

    // Clocks remaining until the last scheduled data beat, relative to the next edge
    always_ff @(posedge clk) begin
        if (reset) begin
            sched_rem_r <= '0;
        end else if (rd_acc_s) begin
            sched_rem_r <= REM_W'(CAS_LATENCY + BURST_LENGTH - 2);
        end else if (wr_acc_s) begin
            sched_rem_r <= REM_W'(CAS_WRITE_LATENCY + BURST_LENGTH - 2);
        end else if (sched_rem_r != '0) begin
            sched_rem_r <= sched_rem_r - REM_W'(1);
        end
    end

    // Latency pipes; valid bits flush on reset so pending bursts are dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld_r <= '0;
            wr_vld_r <= '0;
        end else begin
            rd_vld_r <= {rd_vld_r[CAS_LATENCY-2:0], rd_acc_s};
            wr_vld_r <= {wr_vld_r[CAS_WRITE_LATENCY-2:0], wr_acc_s};
        end
    end

    // Column travels alongside its valid bit through the latency pipes
    always_ff @(posedge clk) begin
        rd_col_r[0] <= address[SDB-1:0];
        for (int i = 1; i < CAS_LATENCY; i++) begin
            rd_col_r[i] <= rd_col_r[i-1];
        end
        wr_col_r[0] <= address[SDB-1:0];
        for (int i = 1; i < CAS_WRITE_LATENCY; i++) begin
            wr_col_r[i] <= wr_col_r[i-1];
        end
    end

    // Beat to serve on this edge: a burst start from a pipe, else the running burst
    always_comb begin
        beat_go_s  = 1'b0;
        beat_wr_s  = 1'b0;
        beat_idx_s = 3'd0;
        beat_col_s = '0;
        if (rd_vld_r[CAS_LATENCY-1]) begin
            beat_go_s  = 1'b1;
            beat_col_s = rd_col_r[CAS_LATENCY-1];
        end else if (wr_vld_r[CAS_WRITE_LATENCY-1]) begin
            beat_go_s  = 1'b1;
            beat_wr_s  = 1'b1;
            beat_col_s = wr_col_r[CAS_WRITE_LATENCY-1];
        end else if (burst_active_r) begin
            beat_go_s  = 1'b1;
            beat_wr_s  = burst_wr_r;
            beat_idx_s = burst_beat_r;
            beat_col_s = burst_col_r;
        end else begin
            beat_go_s  = 1'b0;
        end
    end

    // Sequential wrap inside the aligned 8-word block
    assign beat_wrap_s = beat_col_s[2:0] + beat_idx_s;
    assign beat_addr_s = {beat_col_s[SDB-1:3], beat_wrap_s};
    assign rd_beat_s   = beat_go_s && !beat_wr_s;

    // Burst engine: remembers direction, column and next beat index
    always_ff @(posedge clk) begin
        if (reset) begin
            burst_active_r <= 1'b0;
            burst_beat_r   <= 3'd0;
            burst_wr_r     <= 1'b0;
            burst_col_r    <= '0;
        end else if (beat_go_s) begin
            burst_active_r <= (beat_idx_s != 3'd7);
            burst_beat_r   <= beat_idx_s + 3'd1;
            burst_wr_r     <= beat_wr_s;
            burst_col_r    <= beat_col_s;
        end else begin
            burst_active_r <= 1'b0;
        end
    end

    // Write beats land in storage on their own edge; storage itself is never cleared
    always_ff @(posedge clk) begin
        if (!reset && beat_go_s && beat_wr_s) begin
            mem_r[beat_addr_s] <= dq_in;
        end
    end

    // Registered read data, enable and strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            dq_out_r  <= '0;
            dq_oe_r   <= 1'b0;
            dqs_out_r <= 1'b0;
        end else begin
            dq_oe_r   <= rd_beat_s;
            dqs_out_r <= rd_beat_s && !beat_idx_s[0];
            dq_out_r  <= rd_beat_s ? mem_r[beat_addr_s] : '0;
        end
    end

    // Error pulse, saturating error counter and wrapping refresh counter
    always_ff @(posedge clk) begin
        if (reset) begin
            protocol_error_r <= 1'b0;
            error_count_r    <= 8'd0;
            refresh_count_r  <= 16'd0;
        end else begin
            protocol_error_r <= cmd_err_s;
            if (cmd_err_s && (error_count_r != 8'hFF)) begin
                error_count_r <= error_count_r + 8'd1;
            end
            if (ref_ok_s) begin
                refresh_count_r <= refresh_count_r + 16'd1;
            end
        end
    end

    // Open-row record is kept for visibility only; fold it so it is not dangling
    always_comb begin
        row_fold_s = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            row_fold_s = row_fold_s ^ bank_row_r[i];
        end
    end

    assign unused_s = parity_f({row_fold_s, address});

    assign dq_out         = dq_out_r;
    assign dq_oe          = dq_oe_r;
    assign dqs_out        = dqs_out_r;
    assign dqs_oe         = dq_oe_r;
    assign protocol_error = protocol_error_r;
    assign error_count    = error_count_r;
    assign refresh_count  = refresh_count_r;

endmodule

// File: tb/tb_ddr3_command_responder.sv
// Directed bench for ddr3_command_responder: write/read bursts, wrap order,
// protocol rejections, gapless and colliding reads, refresh and mid-burst reset.

module tb_ddr3_command_responder;

    logic        clk;
    logic        reset;
    logic        ck_en;
    logic        cs_n;
    logic        ras_n;
    logic        cas_n;
    logic        we_n;
    logic [14:0] address;
    logic [2:0]  bank_address;
    logic [15:0] dq_in;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic        dqs_out;
    logic        dqs_oe;
    logic        protocol_error;
    logic [7:0]  error_count;
    logic [15:0] refresh_count;

    int vectors;
    int miscompares;

    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_RD  = 3'b101;

    ddr3_command_responder dut (
        .clk            (clk),
        .reset          (reset),
        .ck_en          (ck_en),
        .cs_n           (cs_n),
        .ras_n          (ras_n),
        .cas_n          (cas_n),
        .we_n           (we_n),
        .address        (address),
        .bank_address   (bank_address),
        .dq_in          (dq_in),
        .dq_out         (dq_out),
        .dq_oe          (dq_oe),
        .dqs_out        (dqs_out),
        .dqs_oe         (dqs_oe),
        .protocol_error (protocol_error),
        .error_count    (error_count),
        .refresh_count  (refresh_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cmd(input logic [2:0] c, input logic [2:0] ba, input logic [14:0] a);
        cs_n = 1'b0;
        {ras_n, cas_n, we_n} = c;
        bank_address = ba;
        address = a;
    endtask

    // One rising edge, then back to NOP; outputs of that edge are observed on return
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cs_n = 1'b1;
        {ras_n, cas_n, we_n} = 3'b111;
        bank_address = 3'd0;
        address = 15'd0;
    endtask

    // Words 0..7 hold value index+1, so beat b of column c reads ((c+b)&7)+1
    task automatic read_burst(input logic [2:0] ba, input logic [9:0] col, input string tag);
        logic [15:0] exp;
        cmd(C_RD, ba, {5'd0, col});
        step();
        check({tag, "_perr"}, {31'd0, protocol_error}, 32'd0);
        for (int k = 1; k <= 13; k++) begin
            step();
            if (k >= 5 && k <= 12) begin
                exp = 16'(((int'(col) + k - 5) & 7) + 1);
                check({tag, "_data"}, {16'd0, dq_out}, {16'd0, exp});
                check({tag, "_oe"}, {31'd0, dq_oe}, 32'd1);
                check({tag, "_dqs"}, {31'd0, dqs_out}, {31'd0, ((k - 5) % 2) == 0});
                check({tag, "_dqsoe"}, {31'd0, dqs_oe}, 32'd1);
            end else if (k == 4 || k == 13) begin
                check({tag, "_oe_edge"}, {31'd0, dq_oe}, 32'd0);
            end
        end
    endtask

    initial begin
        logic [15:0] exp;
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        ck_en = 1'b1;
        cs_n = 1'b1;
        {ras_n, cas_n, we_n} = 3'b111;
        address = 15'd0;
        bank_address = 3'd0;
        dq_in = 16'd0;
        step();
        step();
        check("rst_dq_out", {16'd0, dq_out}, 32'd0);
        check("rst_dq_oe", {31'd0, dq_oe}, 32'd0);
        check("rst_dqs", {31'd0, dqs_out}, 32'd0);
        check("rst_dqs_oe", {31'd0, dqs_oe}, 32'd0);
        check("rst_perr", {31'd0, protocol_error}, 32'd0);
        check("rst_errcnt", {24'd0, error_count}, 32'd0);
        check("rst_refcnt", {16'd0, refresh_count}, 32'd0);
        reset = 1'b0;
        step();

        // ACT b0 row 5, then WR col 0 with 1..8 on the beat edges
        cmd(C_ACT, 3'd0, 15'd5);
        step();
        cmd(C_WR, 3'd0, 15'd0);
        step();
        check("wr_perr", {31'd0, protocol_error}, 32'd0);
        for (int k = 1; k <= 13; k++) begin
            if (k >= 5 && k <= 12) dq_in = 16'(k - 4);
            else dq_in = 16'hDEAD;
            step();
            check("wr_no_oe", {31'd0, dq_oe}, 32'd0);
        end
        read_burst(3'd0, 10'd0, "rd_col0");
        read_burst(3'd0, 10'd6, "rd_col6");
        check("errcnt_clean", {24'd0, error_count}, 32'd0);

        // RD to closed bank 2
        cmd(C_RD, 3'd2, 15'd0);
        step();
        check("closed_perr", {31'd0, protocol_error}, 32'd1);
        check("closed_errcnt", {24'd0, error_count}, 32'd1);
        for (int k = 1; k <= 8; k++) begin
            step();
            check("closed_no_oe", {31'd0, dq_oe}, 32'd0);
            if (k == 1) check("closed_perr_fall", {31'd0, protocol_error}, 32'd0);
        end

        // Gapless reads 8 clocks apart: col 0 then col 3
        for (int k = 0; k <= 21; k++) begin
            if (k == 0) cmd(C_RD, 3'd0, 15'd0);
            if (k == 8) cmd(C_RD, 3'd0, 15'd3);
            step();
            if (k == 8) check("gapless_perr", {31'd0, protocol_error}, 32'd0);
            if (k >= 5 && k <= 20) begin
                exp = 16'((((k < 13) ? 0 : 3) + ((k - 5) % 8)) % 8 + 1);
                check("gapless_oe", {31'd0, dq_oe}, 32'd1);
                check("gapless_data", {16'd0, dq_out}, {16'd0, exp});
            end else if (k == 21) begin
                check("gapless_oe_end", {31'd0, dq_oe}, 32'd0);
            end
        end

        // Colliding reads 4 clocks apart: second rejected
        for (int k = 0; k <= 17; k++) begin
            if (k == 0 || k == 4) cmd(C_RD, 3'd0, 15'd0);
            step();
            if (k == 4) begin
                check("collide_perr", {31'd0, protocol_error}, 32'd1);
                check("collide_errcnt", {24'd0, error_count}, 32'd2);
            end
            if (k == 5) check("collide_perr_fall", {31'd0, protocol_error}, 32'd0);
            if (k >= 5 && k <= 12) begin
                check("collide_oe", {31'd0, dq_oe}, 32'd1);
                check("collide_data", {16'd0, dq_out}, 32'(k - 4));
            end else if (k >= 13) begin
                check("collide_oe_off", {31'd0, dq_oe}, 32'd0);
            end
        end

        // REF with bank 0 open, then PRE all and REF
        cmd(C_REF, 3'd0, 15'd0);
        step();
        check("ref_open_perr", {31'd0, protocol_error}, 32'd1);
        check("ref_open_errcnt", {24'd0, error_count}, 32'd3);
        check("ref_open_refcnt", {16'd0, refresh_count}, 32'd0);
        cmd(C_PRE, 3'd0, 15'h0400);
        step();
        check("pre_all_perr", {31'd0, protocol_error}, 32'd0);
        cmd(C_REF, 3'd0, 15'd0);
        step();
        check("ref_ok_perr", {31'd0, protocol_error}, 32'd0);
        check("ref_ok_refcnt", {16'd0, refresh_count}, 32'd1);
        check("ref_ok_errcnt", {24'd0, error_count}, 32'd3);

        // Reset while beat 3 of a read is on the bus
        cmd(C_ACT, 3'd0, 15'd9);
        step();
        cmd(C_RD, 3'd0, 15'd0);
        step();
        for (int k = 1; k <= 8; k++) step();
        check("mid_beat3_oe", {31'd0, dq_oe}, 32'd1);
        check("mid_beat3_data", {16'd0, dq_out}, 32'd4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_oe", {31'd0, dq_oe}, 32'd0);
        check("mid_rst_data", {16'd0, dq_out}, 32'd0);
        check("mid_rst_errcnt", {24'd0, error_count}, 32'd0);
        check("mid_rst_refcnt", {16'd0, refresh_count}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            step();
            check("post_rst_oe", {31'd0, dq_oe}, 32'd0);
        end
        cmd(C_RD, 3'd0, 15'd0);
        step();
        check("post_rst_rd_perr", {31'd0, protocol_error}, 32'd1);
        check("post_rst_rd_errcnt", {24'd0, error_count}, 32'd1);
        cmd(C_ACT, 3'd0, 15'd1);
        step();
        check("post_rst_act_perr", {31'd0, protocol_error}, 32'd0);
        read_burst(3'd0, 10'd0, "rd_kept");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ddr3_command_responder.md
# ddr3_command_responder

Synthesizable, cycle-accurate single-data-rate model of the DDR3 device side of the command/data interface driven by `ddr3_memory_controller`. It decodes CKE/CS#/RAS#/CAS#/WE# commands, tracks per-bank open rows, stores write bursts in a small on-chip array, and returns read bursts after CAS latency. It sits in the FPGA loopback build in place of the external DDR3 chip, so the controller and the user-side test sequencer can be exercised on-board or in simulation without a memory model.

## Interface
- `ADDRESS_BITWIDTH`, 15: row/column address width.
- `BANK_ADDRESS_BITWIDTH`, 3: bank address width (8 banks).
- `DQ_BITWIDTH`, 16: data word width.
- `CAS_LATENCY`, 5: read command to first read beat, in clocks (≥2).
- `CAS_WRITE_LATENCY`, 5: write command to first write beat, in clocks (≥2).
- `BURST_LENGTH`, 8: beats per burst (fixed 8).
- `STORAGE_DEPTH_BITS`, 6: log2 of storage words (≥3, ≤10).

- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `ck_en` in 1: CKE; low forces every command to NOP.
- `cs_n`, `ras_n`, `cas_n`, `we_n` in 1 each: command pins.
- `address` in ADDRESS_BITWIDTH: row (ACT), column [9:0] and A10 (RD/WR/PRE).
- `bank_address` in BANK_ADDRESS_BITWIDTH: target bank.
- `dq_in` in DQ_BITWIDTH: write data from controller.
- `dq_out` out DQ_BITWIDTH: read data; 0 when not driving.
- `dq_oe` out 1: high during read beats.
- `dqs_out` out 1: read strobe; 1 on even beats, 0 on odd beats, 0 otherwise.
- `dqs_oe` out 1: equals `dq_oe`.
- `protocol_error` out 1: one-cycle pulse per rejected command.
- `error_count` out 8: rejected commands, saturates at 255.
- `refresh_count` out 16: accepted REF commands, wraps.

## Operation
- Decode when `ck_en`=1 and `cs_n`=0, {ras_n,cas_n,we_n}: 000 MRS, 001 REF, 010 PRE, 011 ACT, 100 WR, 101 RD, 110 ZQ, 111 NOP. `cs_n`=1 or `ck_en`=0 is NOP. MRS and ZQ are accepted and have no effect.
- Bank table: per bank `open` flag and row. ACT on a closed bank opens it. ACT on an open bank is rejected.
- PRE with A10=0 closes `bank_address`, and A10=1 closes all banks. PRE on a closed bank is legal.
- REF with all banks closed increments `refresh_count`. REF with any bank open is rejected.
- RD/WR to a closed bank is rejected.
- Data window for RD is [T+CAS_LATENCY, T+CAS_LATENCY+7]. For WR it is [T+CAS_WRITE_LATENCY, T+CAS_WRITE_LATENCY+7]. T is the command edge.
- A RD/WR is rejected if its window starts at or before the end of any already-scheduled window. Gapless back-to-back at 8-clock spacing is legal when latencies are equal.
- Beat address for beat b (0..7), with column c = `address[9:0]`: {c[STORAGE_DEPTH_BITS-1:3], (c[2:0]+b) mod 8}. This is DDR3 sequential wrap within the aligned 8-word block. Bank and row do not take part in indexing, so aliasing across banks and rows is intended.
- Rejected commands change no state except `protocol_error` and `error_count`.
- Storage is not cleared by reset.

## Timing
- Reset values: `dq_out`=0, `dq_oe`=0, `dqs_out`=0, `dqs_oe`=0, `protocol_error`=0, `error_count`=0, `refresh_count`=0. All banks are closed and scheduled windows are flushed.
- Reset asserted mid-burst: `dq_oe` is low from the next edge, and pending write beats are discarded.
- RD at edge T: `dq_out`/`dq_oe` update on edge T+CAS_LATENCY+b for beat b, registered. `dq_oe` falls at T+CAS_LATENCY+8 unless a gapless burst follows.
- WR at edge T: `dq_in` is sampled on edges T+CAS_WRITE_LATENCY+b and written the same edge. A later read of that word returns the new data.
- `protocol_error` is high for exactly the clock after the offending command edge. `error_count` updates on the same edge.
- `ck_en` low does not stall scheduled bursts; they complete.
- Bank table updates on the command edge, so ACT then RD on the next clock is accepted.

## Test plan
- Reset; ACT b0 row 5; WR col 0 with `dq_in` 0x0001..0x0008 at beats; RD col 0 → `dq_out` 0x0001..0x0008 on edges T+5..T+12, `dqs_out` 1,0,1,0..., `error_count`=0.
- After the above, RD col 6 → beats 0x0007,0x0008,0x0001..0x0006 (wrap within block).
- RD to closed bank 2 → `protocol_error` one-cycle pulse, `error_count`=1, `dq_oe` stays 0.
- Two RDs 8 clocks apart → 16 contiguous beats with `dq_oe` never low. Two RDs 4 clocks apart → second rejected, only 8 beats, `error_count`+1.
- REF with b0 open → rejected, `refresh_count`=0. PRE A10=1 then REF → `refresh_count`=1.
- Reset on beat 3 of a read → `dq_oe`=0 next edge. Subsequent RD without ACT is rejected (banks closed), while earlier stored data remains readable after ACT.
